// File: rtl/mold_udp_parser.sv
// rtl/mold_udp_parser.sv - MoldUDP64 over Ethernet/IPv4/UDP parser emitting ITCH message bytes
// Optional macro SEQ_GAP_DETECT_EN enables sequence gap and duplicate-frame detection.
module mold_udp_parser #(
  parameter logic [47:0] DEVICE_MAC_P = 48'h0,
  parameter logic [15:0] UDP_PORT_P   = 16'h0,
  parameter int unsigned MSG_LEN_W    = 16
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  dataIn,
  input  logic        dataValidIn,
  input  logic        dataErrIn,
  output logic [7:0]  itchDataOut,
  output logic        itchDataValidOut,
  output logic        itchSopOut,
  output logic        itchEopOut,
  output logic        itchErrOut,
  output logic        seqGapOut,
  output logic [63:0] expSeqOut,
  output logic        frameDropOut
);

  typedef enum logic [2:0] {IDLE, ETH, IP, UDP, MOLD, MSG_LEN, MSG_DATA, DROP} state_t;

  state_t               state_q;
  logic [4:0]           cnt_q;
  logic [7:0]           hi_q;
  logic [63:0]          seq_q;
  logic [63:0]          exp_seq_q;
  logic [15:0]          msg_left_q;
  logic [MSG_LEN_W-1:0] len_left_q;
  logic                 first_q;
  logic [7:0]           data_q;
  logic                 valid_q, sop_q, eop_q, err_q, gap_q, drop_q;
`ifdef SEQ_GAP_DETECT_EN
  logic                 seq_init_q;
`endif

  state_t               cur_d;
  logic [4:0]           idx_d;
  logic                 last_d, bad_d, dup_d, gap_d;
  logic [15:0]          pair_d;
  logic [MSG_LEN_W-1:0] len_d;
  logic [63:0]          new_exp_d;

  // The first byte of a frame arrives while still in IDLE and is parsed as ETH byte 0.
  assign cur_d     = (state_q == IDLE) ? ETH : state_q;
  assign idx_d     = (state_q == IDLE) ? 5'd0 : cnt_q;
  assign pair_d    = {hi_q, dataIn};
  assign len_d     = pair_d[MSG_LEN_W-1:0];
  assign new_exp_d = seq_q + {48'd0, pair_d};

`ifdef SEQ_GAP_DETECT_EN
  assign dup_d = seq_init_q && (seq_q < exp_seq_q);
  assign gap_d = seq_init_q && (seq_q > exp_seq_q);
`else
  assign dup_d = 1'b0;
  assign gap_d = 1'b0;
`endif

  always_comb begin
    last_d = 1'b1;
    bad_d  = 1'b0;
    case (cur_d)
      ETH: begin
        last_d = (idx_d == 5'd13);
        case (idx_d)
          5'd0:    bad_d = (dataIn != DEVICE_MAC_P[47:40]);
          5'd1:    bad_d = (dataIn != DEVICE_MAC_P[39:32]);
          5'd2:    bad_d = (dataIn != DEVICE_MAC_P[31:24]);
          5'd3:    bad_d = (dataIn != DEVICE_MAC_P[23:16]);
          5'd4:    bad_d = (dataIn != DEVICE_MAC_P[15:8]);
          5'd5:    bad_d = (dataIn != DEVICE_MAC_P[7:0]);
          5'd12:   bad_d = (dataIn != 8'h08);
          5'd13:   bad_d = (dataIn != 8'h00);
          default: bad_d = 1'b0;
        endcase
      end
      IP: begin
        last_d = (idx_d == 5'd19);
        if (idx_d == 5'd0)      bad_d = (dataIn != 8'h45);
        else if (idx_d == 5'd9) bad_d = (dataIn != 8'h11);
      end
      UDP: begin
        last_d = (idx_d == 5'd7);
        if (idx_d == 5'd2)      bad_d = (dataIn != UDP_PORT_P[15:8]);
        else if (idx_d == 5'd3) bad_d = (dataIn != UDP_PORT_P[7:0]);
      end
      MOLD:    last_d = (idx_d == 5'd19);
      MSG_LEN: last_d = (idx_d == 5'd1);
      default: last_d = 1'b1;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      seq_q      <= '0;
      exp_seq_q  <= '0;
      msg_left_q <= '0;
      len_left_q <= '0;
      first_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      gap_q      <= 1'b0;
      drop_q     <= 1'b0;
`ifdef SEQ_GAP_DETECT_EN
      seq_init_q <= 1'b0;
`endif
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
      drop_q  <= 1'b0;
      if (!dataValidIn) begin
        // In MSG_LEN/MSG_DATA at least one message is always still outstanding.
        err_q   <= (state_q == MSG_LEN) || (state_q == MSG_DATA);
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (state_q == DROP) begin
        state_q <= DROP;
      end else if (dataErrIn) begin
        err_q   <= (state_q == MSG_DATA);
        drop_q  <= 1'b1;
        state_q <= DROP;
      end else begin
        hi_q  <= dataIn;
        cnt_q <= last_d ? 5'd0 : idx_d + 5'd1;
        case (cur_d)
          ETH, IP, UDP: begin
            if (bad_d) begin
              state_q <= DROP;
              drop_q  <= 1'b1;
            end else if (last_d) begin
              state_q <= (cur_d == ETH) ? IP : (cur_d == IP) ? UDP : MOLD;
            end else begin
              state_q <= cur_d;
            end
          end
          MOLD: begin
            if (idx_d >= 5'd10 && idx_d <= 5'd17) seq_q <= {seq_q[55:0], dataIn};
            if (last_d) begin
              if (dup_d) begin
                state_q <= DROP;
                drop_q  <= 1'b1;
              end else begin
                exp_seq_q  <= new_exp_d;
                gap_q      <= gap_d;
                msg_left_q <= pair_d;
`ifdef SEQ_GAP_DETECT_EN
                seq_init_q <= 1'b1;
`endif
                state_q    <= (pair_d == 16'd0) ? DROP : MSG_LEN;
              end
            end
          end
          MSG_LEN: begin
            if (last_d) begin
              if (len_d == '0) begin
                msg_left_q <= msg_left_q - 16'd1;
                state_q    <= (msg_left_q == 16'd1) ? DROP : MSG_LEN;
              end else begin
                len_left_q <= len_d;
                first_q    <= 1'b1;
                state_q    <= MSG_DATA;
              end
            end
          end
          MSG_DATA: begin
            data_q     <= dataIn;
            valid_q    <= 1'b1;
            sop_q      <= first_q;
            first_q    <= 1'b0;
            len_left_q <= len_left_q - MSG_LEN_W'(1);
            if (len_left_q == MSG_LEN_W'(1)) begin
              eop_q      <= 1'b1;
              msg_left_q <= msg_left_q - 16'd1;
              state_q    <= (msg_left_q == 16'd1) ? DROP : MSG_LEN;
            end
          end
          default: state_q <= DROP;
        endcase
      end
    end
  end

  assign itchDataOut      = data_q;
  assign itchDataValidOut = valid_q;
  assign itchSopOut       = sop_q;
  assign itchEopOut       = eop_q;
  assign itchErrOut       = err_q;
  assign seqGapOut        = gap_q;
  assign expSeqOut        = exp_seq_q;
  assign frameDropOut     = drop_q;

endmodule

// File: tb/tb_mold_udp_parser.sv
// tb/tb_mold_udp_parser.sv - table-driven and randomized bench for mold_udp_parser
// Expectations follow SEQ_GAP_DETECT_EN when the bench is built with it.
module tb_mold_udp_parser;

  localparam logic [47:0] MAC  = 48'h02_11_22_33_44_55;
  localparam logic [15:0] PORT = 16'h4E21;
`ifdef SEQ_GAP_DETECT_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  typedef logic [7:0]  bq_t[$];
  typedef logic [9:0]  eq_t[$];
  typedef struct {
    logic [63:0] seq;
    int nmsg, len0, len1, len2, bad, pad, err_at, rst_at, cut;
    int e_bytes, e_drop, e_err, e_gap;
    logic [63:0] e_exp;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, dvalid = 1'b0, derr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  itch_data;
  logic        itch_valid, itch_sop, itch_eop, itch_err, seq_gap, frame_drop;
  logic [63:0] exp_seq;

  mold_udp_parser #(.DEVICE_MAC_P(MAC), .UDP_PORT_P(PORT), .MSG_LEN_W(16)) dut (
    .clkIn(clk), .rstIn(rst), .dataIn(din), .dataValidIn(dvalid), .dataErrIn(derr),
    .itchDataOut(itch_data), .itchDataValidOut(itch_valid), .itchSopOut(itch_sop),
    .itchEopOut(itch_eop), .itchErrOut(itch_err), .seqGapOut(seq_gap),
    .expSeqOut(exp_seq), .frameDropOut(frame_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: each captured byte carries the cycle it appeared in.
  logic [41:0] obs[$];
  int n_err = 0, n_gap = 0, n_drop = 0;
  always @(negedge clk) begin
    if (itch_valid) obs.push_back({32'(cyc), itch_sop, itch_eop, itch_data});
    if (itch_err) n_err++;
    if (seq_gap) n_gap++;
    if (frame_drop) n_drop++;
  end

  int n_tests = 0, n_fail = 0;
  vec_t vt[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic build_frame(input logic [63:0] seq, input int lens[$], input int bad,
                             input int pad, output bq_t fr, output eq_t ex);
    logic [47:0] mac;
    logic [15:0] etype, cnt, l;
    logic [7:0]  b;
    mac   = (bad == 2) ? (MAC ^ 48'h0000_0000_0100) : MAC;
    etype = (bad == 3) ? 16'h86DD : 16'h0800;
    cnt   = 16'(lens.size());
    fr = {};
    ex = {};
    for (int i = 5; i >= 0; i--) fr.push_back(mac[8*i +: 8]);
    repeat (6) fr.push_back(8'($urandom));
    fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
    fr.push_back(8'h45);
    repeat (8) fr.push_back(8'($urandom));
    fr.push_back((bad == 4) ? 8'h06 : 8'h11);
    repeat (10) fr.push_back(8'($urandom));
    repeat (2) fr.push_back(8'($urandom));
    fr.push_back((bad == 1) ? ~PORT[15:8] : PORT[15:8]);
    fr.push_back(PORT[7:0]);
    repeat (4) fr.push_back(8'($urandom));
    repeat (10) fr.push_back(8'($urandom));
    for (int i = 7; i >= 0; i--) fr.push_back(seq[8*i +: 8]);
    fr.push_back(cnt[15:8]); fr.push_back(cnt[7:0]);
    foreach (lens[m]) begin
      l = 16'(lens[m]);
      fr.push_back(l[15:8]); fr.push_back(l[7:0]);
      for (int j = 0; j < lens[m]; j++) begin
        b = 8'($urandom);
        fr.push_back(b);
        ex.push_back({j == 0, j == lens[m] - 1, b});
      end
    end
    repeat (pad) fr.push_back(8'($urandom));
  endtask

  task automatic send_frame(input bq_t fr, input int err_at, input int rst_at, output int first_in);
    first_in = -1;
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      if (i == rst_at) begin
        dvalid = 1'b0; derr = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_outputs", {itch_valid, itch_sop, itch_eop, itch_err, seq_gap, frame_drop, itch_data}, 64'd0);
        check("rst_mid_expseq", exp_seq, 64'd0);
        break;
      end
      din = fr[i]; dvalid = 1'b1; derr = (i == err_at);
      if (i == 64) first_in = cyc;
    end
    @(posedge clk); #1;
    dvalid = 1'b0; derr = 1'b0; din = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input eq_t ex, input int e_bytes, input int b0,
                         input int err0, input int gap0, input int drop0, input int first_in,
                         input bit chk_lat, input int e_err, input int e_gap, input int e_drop,
                         input logic [63:0] e_exp);
    int nb, k;
    nb = obs.size() - b0;
    check({tag, "_bytes"}, 64'(nb), 64'(e_bytes));
    if (nb > 0 && ex.size() > 0) begin
      k = 0;
      for (int i = 0; i < nb && i < ex.size(); i++)
        if (obs[b0+i][9:0] !== ex[i]) begin k = i; break; end
      check({tag, "_data"}, 64'(obs[b0+k][9:0]), 64'(ex[k]));
      if (chk_lat) check({tag, "_latency"}, 64'(int'(obs[b0][41:10]) - first_in), 64'd1);
    end
    check({tag, "_itch_err"}, 64'(n_err - err0), 64'(e_err));
    check({tag, "_seq_gap"}, 64'(n_gap - gap0), 64'(e_gap));
    check({tag, "_frame_drop"}, 64'(n_drop - drop0), 64'(e_drop));
    check({tag, "_exp_seq"}, exp_seq, e_exp);
  endtask

  initial begin
    bq_t fr;
    eq_t ex;
    int lens[$];
    int b0, err0, gap0, drop0, fin, kind, n, bad;
    logic [63:0] seq, exp_m;

    //            seq  n  l0 l1 l2 bad pad err rst cut   bytes drop err gap exp
    vt[0]  = '{64'd1,  1, 36, 0, 0, 0, 0, -1, -1, -1,   36, 0, 0, 0, 64'd2};
    vt[1]  = '{64'd3,  1, 20, 0, 0, 0, 0, -1, -1, -1,   20, 0, 0, G, 64'd4};
`ifdef SEQ_GAP_DETECT_EN
    vt[2]  = '{64'd2,  1, 10, 0, 0, 0, 0, -1, -1, -1,    0, 1, 0, 0, 64'd4};
`else
    vt[2]  = '{64'd2,  1, 10, 0, 0, 0, 0, -1, -1, -1,   10, 0, 0, 0, 64'd3};
`endif
    vt[3]  = '{64'd4,  3, 36, 0, 1, 0, 0, -1, -1, -1,   37, 0, 0, 0, 64'd7};
    vt[4]  = '{64'd7,  1,  5, 0, 0, 1, 0, -1, -1, -1,    0, 1, 0, 0, 64'd7};
    vt[5]  = '{64'd7,  1,  8, 0, 0, 0, 6, -1, -1, -1,    8, 0, 0, 0, 64'd8};
    vt[6]  = '{64'd8,  1,  3, 0, 0, 2, 0, -1, -1, -1,    0, 1, 0, 0, 64'd8};
    vt[7]  = '{64'd8,  1,  3, 0, 0, 3, 0, -1, -1, -1,    0, 1, 0, 0, 64'd8};
    vt[8]  = '{64'd8,  1,  3, 0, 0, 4, 0, -1, -1, -1,    0, 1, 0, 0, 64'd8};
    vt[9]  = '{64'd8,  0,  0, 0, 0, 0, 4, -1, -1, -1,    0, 0, 0, 0, 64'd8};
    vt[10] = '{64'd8,  1, 20, 0, 0, 0, 0, 74, -1, -1,   10, 1, 1, 0, 64'd9};
    vt[11] = '{64'd9,  2,  3, 3, 0, 0, 0, -1, -1, 68,    3, 0, 1, 0, 64'd11};
    vt[12] = '{64'd11, 1, 12, 0, 0, 0, 0, -1, 69, -1,    5, 0, 0, 0, 64'd0};
    vt[13] = '{64'd9,  1,  4, 0, 0, 0, 0, -1, -1, -1,    4, 0, 0, 0, 64'd10};
    vt[14] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 1, 0, 0, 0, -1, -1, -1, 3, 0, 0, G, 64'd1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {itch_valid, itch_sop, itch_eop, itch_err, seq_gap, frame_drop}, 64'd0);
    check("reset_data", 64'(itch_data), 64'd0);
    check("reset_expseq", exp_seq, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      lens = {};
      if (vt[v].nmsg > 0) lens.push_back(vt[v].len0);
      if (vt[v].nmsg > 1) lens.push_back(vt[v].len1);
      if (vt[v].nmsg > 2) lens.push_back(vt[v].len2);
      build_frame(vt[v].seq, lens, vt[v].bad, vt[v].pad, fr, ex);
      if (vt[v].cut >= 0) while (fr.size() > vt[v].cut) void'(fr.pop_back());
      while (ex.size() > vt[v].e_bytes) void'(ex.pop_back());
      b0 = obs.size(); err0 = n_err; gap0 = n_gap; drop0 = n_drop;
      send_frame(fr, vt[v].err_at, vt[v].rst_at, fin);
      compare($sformatf("vec%0d", v), ex, vt[v].e_bytes, b0, err0, gap0, drop0, fin,
              vt[v].e_bytes > 0, vt[v].e_err, vt[v].e_gap, vt[v].e_drop, vt[v].e_exp);
    end

    // Random frames against a field-level model of acceptance and sequencing.
    exp_m = 64'd1;
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(0, 3);
      bad  = 0;
      seq  = exp_m;
      lens = {};
      for (int m = 0; m < n; m++) lens.push_back($urandom_range(0, 12));
      if (kind == 0) bad = $urandom_range(1, 4);
      else if (kind == 1 && exp_m > 64'd3) seq = exp_m - 64'($urandom_range(1, 3));
      else if (kind == 2) seq = exp_m + 64'($urandom_range(1, 5));
      build_frame(seq, lens, bad, $urandom_range(0, 3), fr, ex);
      b0 = obs.size(); err0 = n_err; gap0 = n_gap; drop0 = n_drop;
      send_frame(fr, -1, -1, fin);
      if (bad != 0 || (G == 1 && seq < exp_m)) begin
        ex = {};
        compare($sformatf("rnd%0d", r), ex, 0, b0, err0, gap0, drop0, fin, 1'b0, 0, 0, 1, exp_m);
      end else begin
        compare($sformatf("rnd%0d", r), ex, ex.size(), b0, err0, gap0, drop0, fin, 1'b0, 0,
                (G == 1 && seq > exp_m) ? 1 : 0, 0, seq + 64'(n));
        exp_m = seq + 64'(n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/mold_udp_parser.md
MOLD_UDP_PARSER -- requirements
Module: mold_udp_parser

Interface
REQ-001 The block SHALL have parameter DEVICE_MAC_P, default 48'h0, meaning destination MAC accepted.
REQ-002 The block SHALL have parameter UDP_PORT_P, default 16'h0, meaning UDP destination port accepted.
REQ-003 The block SHALL have parameter MSG_LEN_W, default 16, meaning width of the per-message byte counter (1..16).
REQ-004 The block SHALL have port clkIn, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstIn, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port dataIn, input, 8, the frame byte, first byte is the MSB of the Ethernet destination MAC.
REQ-007 The block SHALL have port dataValidIn, input, 1; high for every byte of a frame, low between frames.
REQ-008 The block SHALL have port dataErrIn, input, 1, the PHY error flag, sampled with dataValidIn.
REQ-009 The block SHALL have ports itchDataOut (output, 8), itchDataValidOut (1), itchSopOut (1) and itchEopOut (1), carrying the ITCH message bytes with first-byte and last-byte markers.
REQ-010 The block SHALL have port itchErrOut, output, 1, a one-cycle pulse when a message already started is truncated or corrupted.
REQ-011 The block SHALL have ports seqGapOut (output, 1), a one-cycle pulse on a detected sequence gap, and expSeqOut (output, 64), the next expected MoldUDP64 sequence number.
REQ-012 The block SHALL have port frameDropOut, output, 1, a one-cycle pulse when a frame is discarded.

Function
REQ-013 The state machine SHALL have states IDLE, ETH (14 B), IP (20 B), UDP (8 B), MOLD (20 B: session 10, seq 8, count 2), MSG_LEN (2 B), MSG_DATA and DROP.
REQ-014 The first valid byte in IDLE SHALL enter ETH; each state SHALL advance when its byte counter reaches its length minus one.
REQ-015 Filter: dest MAC SHALL equal DEVICE_MAC_P, ethertype 0x0800, IP byte0 0x45, protocol 0x11 and UDP dest port UDP_PORT_P; any mismatch SHALL go to DROP and pulse frameDropOut once.
REQ-016 In MOLD the block SHALL capture seqNum and msgCnt; msgCnt==0 (heartbeat) SHALL go to DROP with no frameDropOut pulse.
REQ-017 In MSG_LEN the block SHALL load the 2-byte big-endian length; length 0 SHALL count as a message, emit nothing and return to MSG_LEN or DROP.
REQ-018 In MSG_DATA each input byte SHALL appear on itchDataOut with itchDataValidOut exactly 1 cycle later; SOP SHALL be set on the first byte, EOP on the last byte, and both on a 1-byte message.
REQ-019 After the message numbered msgCnt, the block SHALL go to DROP; trailing padding SHALL be ignored without a pulse.
REQ-020 DROP SHALL hold until dataValidIn is low, then return to IDLE.
REQ-021 dataValidIn low in any state other than IDLE/DROP SHALL return to IDLE; if in MSG_LEN/MSG_DATA with messages outstanding, itchErrOut SHALL pulse.
REQ-022 dataErrIn high SHALL go to DROP, pulse frameDropOut, and also pulse itchErrOut if in MSG_DATA; that byte SHALL NOT be output.
REQ-023 On an accepted MOLD header, expSeqOut SHALL update to seqNum+msgCnt (64-bit, wrap modulo 2^64).

Reset
REQ-024 rstIn SHALL force IDLE, clear all counters, drive every output to 0 (expSeqOut=0) and clear the seq-initialised flag; reset mid-frame SHALL discard the frame with no pulses, and the remainder of that frame SHALL be treated as a new frame.

Configuration
REQ-025 With SEQ_GAP_DETECT_EN defined: the first frame after reset SHALL initialise without a gap; seqNum>expSeqOut SHALL pulse seqGapOut during the cycle after the last MOLD byte; seqNum<expSeqOut (duplicate) SHALL drop the frame with a frameDropOut pulse; equal SHALL pass. Without it, seqGapOut SHALL tie to 0 and every sequence number SHALL be accepted.

Verification
REQ-026 One frame, seq 1, count 1, 36-byte add order -> 36 bytes, SOP on byte 0, EOP on byte 35, expSeqOut=2.
REQ-027 Next frame with seq 3 (macro on) -> seqGapOut pulses once, data still output, expSeqOut=4; resend seq 2 -> frameDropOut, no output.
REQ-028 Count 3, lengths 36/0/1 -> two output messages; the 1-byte message has SOP and EOP together; expSeqOut advances by 3.
REQ-029 UDP port mismatch -> frameDropOut pulse, no itchDataValidOut; following good frame parsed normally.
REQ-030 dataErrIn at message byte 10 -> itchErrOut and frameDropOut pulse, 10 bytes output, no EOP.
REQ-031 rstIn at message byte 5 -> outputs 0 next cycle; next good frame (seq 9) accepted with no gap pulse.
